pcpi_result_serializer: RTL and testbench

Downstream companion to the nibble-serial instruction loader and the fused matrix-multiply PCPI unit. It captures every 32-bit PCPI result (`pcpi_rd` qualified by `pcpi_ready && pcpi_wr`) into a small FIFO. It then returns each word to the off-chip host as a sequence of 4-bit nibbles over a 4-phase valid/ack handshake. This closes the loop the loader opens: instructions go in nibble by nibble, and results come out the same way.

---
 rtl/pcpi_result_serializer.sv | 161 ++++++++++++++++
 tb/tb_pcpi_result_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_result_serializer.sv
// pcpi_result_serializer
// Captures PCPI result words into a small FIFO and streams each word to an
// off-chip host as eight 4-bit nibbles over a 4-phase valid/ack handshake.
module pcpi_result_serializer #(
  parameter int FIFO_DEPTH = 2,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pcpi_ready,
  input  logic                          pcpi_wr,
  input  logic [31:0]                   pcpi_rd,
  input  logic                          host_ack,
  output logic [3:0]                    nib_out,
  output logic                          nib_valid,
  output logic                          word_done,
  output logic                          busy,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t         state_reg;
  logic [31:0]    sr_reg;
  logic [2:0]     idx_reg;
  logic [3:0]     nib_out_reg;
  logic           nib_valid_reg;
  logic           word_done_reg;
  logic           overrun_reg;

  logic [31:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;

  logic           push_req;
  logic           fifo_full;
  logic           pop;
  logic           push;
  logic           drop;
  logic [31:0]    fifo_head;
  logic [31:0]    sr_shifted;

  // The nibble presented first from a word (or from a freshly shifted word).
  function automatic logic [3:0] lead_nibble(input logic [31:0] w);
    return MSB_FIRST ? w[31:28] : w[3:0];
  endfunction

  // Handshake/FIFO control. A full FIFO still accepts a push on the edge
  // that pops, because the freed slot is exactly the one being written.
  always_comb begin
    push_req   = pcpi_ready && pcpi_wr;
    fifo_full  = (count_reg == FULL_COUNT);
    pop        = (state_reg == IDLE) && (count_reg != '0);
    push       = push_req && (!fifo_full || pop);
    drop       = push_req && fifo_full && !pop;
    fifo_head  = fifo_mem[rd_ptr_reg];
    sr_shifted = MSB_FIRST ? {sr_reg[27:0], 4'h0} : {4'h0, sr_reg[31:4]};
  end

  // FIFO storage; no reset needed since pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_mem[wr_ptr_reg] <= pcpi_rd;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky drop indicator, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_reg <= 1'b0;
    end else if (drop) begin
      overrun_reg <= 1'b1;
    end
  end

  // Serializer FSM with registered nibble/valid/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sr_reg        <= '0;
      idx_reg       <= '0;
      nib_out_reg   <= '0;
      nib_valid_reg <= 1'b0;
      word_done_reg <= 1'b0;
    end else begin
      word_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // host_ack is deliberately ignored while idle
          if (pop) begin
            sr_reg        <= fifo_head;
            idx_reg       <= '0;
            nib_out_reg   <= lead_nibble(fifo_head);
            nib_valid_reg <= 1'b1;
            state_reg     <= SEND;
          end
        end
        SEND: begin
          // an ack still high from before entry counts immediately
          if (host_ack) begin
            nib_valid_reg <= 1'b0;
            state_reg     <= RELEASE;
          end
        end
        RELEASE: begin
          // nib_out holds here until the host releases ack
          if (!host_ack) begin
            if (idx_reg != 3'd7) begin
              sr_reg        <= sr_shifted;
              idx_reg       <= idx_reg + 3'd1;
              nib_out_reg   <= lead_nibble(sr_shifted);
              nib_valid_reg <= 1'b1;
              state_reg     <= SEND;
            end else begin
              word_done_reg <= 1'b1;
              state_reg     <= IDLE;
            end
          end
        end
        default: begin
          nib_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign nib_out    = nib_out_reg;
  assign nib_valid  = nib_valid_reg;
  assign word_done  = word_done_reg;
  assign overrun    = overrun_reg;
  assign fifo_count = count_reg;
  assign busy       = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_pcpi_result_serializer.sv
// Directed testbench for pcpi_result_serializer: LSB-first instance (a) and
// MSB-first instance (b), host handshake modelled by a single receive task.
module tb_pcpi_result_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        rdy_a = 0, wr_a = 0, ack_a = 0;
  logic [31:0] rd_a = '0;
  logic [3:0]  nib_a;
  logic        nv_a, wd_a, busy_a, ovr_a;
  logic [1:0]  cnt_a;

  logic        rdy_b = 0, wr_b = 0, ack_b = 0;
  logic [31:0] rd_b = '0;
  logic [3:0]  nib_b;
  logic        nv_b, wd_b, busy_b, ovr_b;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;
  int done_a = 0;
  int done_b = 0;

  always #5 clk = ~clk;

  pcpi_result_serializer #(.FIFO_DEPTH(2), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .pcpi_ready(rdy_a), .pcpi_wr(wr_a), .pcpi_rd(rd_a),
    .host_ack(ack_a), .nib_out(nib_a), .nib_valid(nv_a), .word_done(wd_a),
    .busy(busy_a), .overrun(ovr_a), .fifo_count(cnt_a)
  );

  pcpi_result_serializer #(.FIFO_DEPTH(2), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .pcpi_ready(rdy_b), .pcpi_wr(wr_b), .pcpi_rd(rd_b),
    .host_ack(ack_b), .nib_out(nib_b), .nib_valid(nv_b), .word_done(wd_b),
    .busy(busy_b), .overrun(ovr_b), .fifo_count(cnt_b)
  );

  // count word_done pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (wd_a) done_a <= done_a + 1;
    if (wd_b) done_b <= done_b + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_nv(input bit sel);
    return sel ? nv_b : nv_a;
  endfunction

  task automatic set_ack(input bit sel, input logic v);
    if (sel) ack_b = v; else ack_a = v;
  endtask

  task automatic wait_valid(input bit sel, input logic lvl);
    int t = 0;
    while (cur_nv(sel) !== lvl && t < 64) begin
      tick();
      t++;
    end
    check(sel ? "b_hs_timeout" : "a_hs_timeout", 32'(t >= 64), 32'd0);
  endtask

  // Host side: take n nibbles, ack after dly cycles, keep ack high for
  // hold extra cycles after valid falls. Returns in the cycle after the
  // final ack release (the word_done cycle for a full word).
  task automatic recv(input bit sel, input int n, input int dly, input int hold,
                      output logic [31:0] w);
    logic [3:0] nib;
    w = '0;
    for (int i = 0; i < n; i++) begin
      wait_valid(sel, 1'b1);
      nib = sel ? nib_b : nib_a;
      if (sel) w = {w[27:0], nib};
      else     w[4*i +: 4] = nib;
      repeat (dly) tick();
      set_ack(sel, 1'b1);
      wait_valid(sel, 1'b0);
      for (int h = 0; h < hold; h++) begin
        tick();
        check(sel ? "b_release_hold" : "a_release_hold", 32'(cur_nv(sel)), 32'd0);
      end
      set_ack(sel, 1'b0);
      tick();
    end
    $display("host%s received %0d nibbles word %h", sel ? "b" : "a", n, w);
  endtask

  task automatic capture_a(input logic [31:0] d);
    rdy_a = 1; wr_a = 1; rd_a = d;
    tick();
    rdy_a = 0; wr_a = 0;
  endtask

  initial begin
    logic [31:0] w;
    int d0;

    // reset state
    repeat (3) tick();
    check("rst_nib_valid", 32'(nv_a), 32'd0);
    check("rst_busy",      32'(busy_a), 32'd0);
    check("rst_count",     32'(cnt_a), 32'd0);
    rst = 0;
    tick();

    // single word with latency check
    d0 = done_a;
    capture_a(32'h89ABCDEF);
    check("cap_count",       32'(cnt_a), 32'd1);
    check("cap_valid_early", 32'(nv_a), 32'd0);
    tick();
    check("first_valid_2cyc", 32'(nv_a), 32'd1);
    check("first_nibble",     32'(nib_a), 32'hF);
    recv(1'b0, 8, 3, 0, w);
    check("single_word", w, 32'h89ABCDEF);
    check("single_word_done_now", 32'(wd_a), 32'd1);
    tick();
    check("single_word_done_cnt", 32'(done_a - d0), 32'd1);
    check("single_busy_after", 32'(busy_a), 32'd0);

    // qualifier: ready without wr is ignored
    rdy_a = 1; wr_a = 0; rd_a = 32'hDEADBEEF;
    tick();
    rdy_a = 0;
    check("qual_count", 32'(cnt_a), 32'd0);
    repeat (2) tick();
    check("qual_count_late", 32'(cnt_a), 32'd0);
    check("qual_valid", 32'(nv_a), 32'd0);

    // overflow with no acks: A to sr, B and C queued, D dropped
    d0 = done_a;
    capture_a(32'h11111111);
    capture_a(32'h22222222);
    capture_a(32'h33333333);
    check("ovf_pre_overrun", 32'(ovr_a), 32'd0);
    capture_a(32'h44444444);
    check("ovf_overrun", 32'(ovr_a), 32'd1);
    check("ovf_count",   32'(cnt_a), 32'd2);
    recv(1'b0, 8, 1, 0, w);
    check("ovf_word_a", w, 32'h11111111);
    recv(1'b0, 8, 1, 0, w);
    check("ovf_word_b", w, 32'h22222222);
    recv(1'b0, 8, 1, 0, w);
    check("ovf_word_c", w, 32'h33333333);
    repeat (4) tick();
    check("ovf_done_cnt", 32'(done_a - d0), 32'd3);
    check("ovf_drained",  32'(cnt_a), 32'd0);
    check("ovf_valid_off", 32'(nv_a), 32'd0);
    check("ovf_sticky",   32'(ovr_a), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    check("rst_clears_overrun", 32'(ovr_a), 32'd0);

    // push/pop collision on a full FIFO while idle
    capture_a(32'hA1A2A3A4);
    capture_a(32'hB1B2B3B4);
    capture_a(32'hC1C2C3C4);
    recv(1'b0, 8, 0, 0, w);
    check("col_w1", w, 32'hA1A2A3A4);
    check("col_idle_full", 32'(cnt_a), 32'd2);
    capture_a(32'hD1D2D3D4);
    check("col_count", 32'(cnt_a), 32'd2);
    check("col_overrun", 32'(ovr_a), 32'd0);
    recv(1'b0, 8, 0, 0, w);
    check("col_w2", w, 32'hB1B2B3B4);
    recv(1'b0, 8, 0, 0, w);
    check("col_w3", w, 32'hC1C2C3C4);
    recv(1'b0, 8, 0, 0, w);
    check("col_w4", w, 32'hD1D2D3D4);
    tick();
    check("col_busy_after", 32'(busy_a), 32'd0);

    // reset mid-word, with a capture on the reset edge
    capture_a(32'h76543210);
    recv(1'b0, 3, 1, 0, w);
    check("mid_partial", 32'(w[11:0]), 32'h210);
    rst = 1;
    rdy_a = 1; wr_a = 1; rd_a = 32'hFFFFFFFF;
    tick();
    rst = 0; rdy_a = 0; wr_a = 0;
    check("mid_rst_nib",   32'(nib_a), 32'd0);
    check("mid_rst_valid", 32'(nv_a), 32'd0);
    check("mid_rst_done",  32'(wd_a), 32'd0);
    check("mid_rst_busy",  32'(busy_a), 32'd0);
    check("mid_rst_ovr",   32'(ovr_a), 32'd0);
    check("mid_rst_count", 32'(cnt_a), 32'd0);
    repeat (2) tick();
    check("mid_rst_drop_cap", 32'(cnt_a), 32'd0);
    check("mid_rst_no_valid", 32'(nv_a), 32'd0);
    capture_a(32'h0000000A);
    recv(1'b0, 8, 1, 0, w);
    check("post_rst_word", w, 32'h0000000A);

    // MSB-first instance with ack already high before the word arrives
    d0 = done_b;
    ack_b = 1;
    repeat (2) tick();
    check("b_idle_ignores_ack", 32'(nv_b), 32'd0);
    rdy_b = 1; wr_b = 1; rd_b = 32'h12345678;
    tick();
    rdy_b = 0; wr_b = 0;
    recv(1'b1, 8, 0, 2, w);
    check("b_msb_word", w, 32'h12345678);
    tick();
    check("b_done_cnt", 32'(done_b - d0), 32'd1);
    check("b_busy_after", 32'(busy_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
